// File: rtl/gb_clk_ctrl.sv
// gb_clk_ctrl
//   Derives the Game Boy core clock from the system clock and lets debug
//   trigger pulses halt and resume it at clean points. A halt always replaces
//   the next rising edge of gb_clk, so the clock never produces a runt phase.
//
// Ports:
//   clk          in   system clock, all logic on its rising edge
//   reset        in   asynchronous, active-high reset
//   trigger      in   toggle request (level); only its rising edge acts
//   gb_clk       out  registered Game Boy clock, 50% duty while running
//   gb_clk_rise  out  one-clk strobe in the cycle gb_clk goes 0->1
//   halt         out  high only while HALTED
//   cycle_count  out  gb_clk rising edges since reset, wraps at 2^32
//
// Parameters:
//   HALF_PERIOD   clk cycles per gb_clk half-period (>= 2)
//   START_HALTED  1: leave reset in HALTED

module gb_clk_ctrl #(
    parameter int HALF_PERIOD  = 12,
    parameter bit START_HALTED = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        trigger,
    output logic        gb_clk,
    output logic        gb_clk_rise,
    output logic        halt,
    output logic [31:0] cycle_count
);

    localparam int CW = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(HALF_PERIOD - 1);

    // RUN: clock free-running. STOP_PEND: running, waiting for the next
    // would-be rise to freeze the clock. HALTED: clock frozen low.
    typedef enum logic [1:0] {
        RUN       = 2'd0,
        STOP_PEND = 2'd1,
        HALTED    = 2'd2
    } state_t;

    localparam state_t RESET_STATE = START_HALTED ? HALTED : RUN;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          gb_clk_q, gb_clk_d;
    logic          rise_q, rise_d;
    logic          halt_q, halt_d;
    logic [31:0]   count_q, count_d;
    logic          trig_q, trig_d;

    logic          trig_edge;
    logic          boundary;

    always_comb begin
        trig_edge = trigger & ~trig_q;
        boundary  = (cnt_q == CNT_LAST);

        state_d  = state_q;
        cnt_d    = cnt_q;
        gb_clk_d = gb_clk_q;
        rise_d   = 1'b0;
        count_d  = count_q;
        trig_d   = trigger;

        case (state_q)
            RUN, STOP_PEND: begin
                cnt_d = boundary ? '0 : cnt_q + CW'(1);
                if (boundary) begin
                    gb_clk_d = ~gb_clk_q;
                    if (!gb_clk_q) begin
                        rise_d  = 1'b1;
                        count_d = count_q + 32'd1;
                    end
                end

                if (state_q == RUN) begin
                    // The clock action of this cycle still happens.
                    if (trig_edge) begin
                        state_d = STOP_PEND;
                    end
                end else if (trig_edge) begin
                    // A cancelling edge wins over a coinciding would-be rise.
                    state_d = RUN;
                end else if (boundary && !gb_clk_q) begin
                    // Freeze low in place of the rise; counter restarts so
                    // the resume produces a full high phase.
                    gb_clk_d = 1'b0;
                    rise_d   = 1'b0;
                    count_d  = count_q;
                    state_d  = HALTED;
                end
            end

            HALTED: begin
                gb_clk_d = 1'b0;
                cnt_d    = '0;
                if (trig_edge) begin
                    // Resume rises straight away: 1 clk of latency.
                    state_d  = RUN;
                    gb_clk_d = 1'b1;
                    rise_d   = 1'b1;
                    count_d  = count_q + 32'd1;
                end
            end

            default: begin
                state_d = RESET_STATE;
            end
        endcase

        halt_d = (state_d == HALTED);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= RESET_STATE;
            cnt_q    <= '0;
            gb_clk_q <= 1'b0;
            rise_q   <= 1'b0;
            halt_q   <= START_HALTED;
            count_q  <= 32'd0;
            trig_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            gb_clk_q <= gb_clk_d;
            rise_q   <= rise_d;
            halt_q   <= halt_d;
            count_q  <= count_d;
            trig_q   <= trig_d;
        end
    end

    assign gb_clk      = gb_clk_q;
    assign gb_clk_rise = rise_q;
    assign halt        = halt_q;
    assign cycle_count = count_q;

endmodule

// File: tb/tb_gb_clk_ctrl.sv
// Directed bench for gb_clk_ctrl with HALF_PERIOD=4. A second instance with
// START_HALTED=1 covers the halted-out-of-reset case. Outputs are sampled
// 1 time unit after the rising clk edge; inputs change at the same point.

module tb_gb_clk_ctrl;

  logic        clk;
  logic        reset;
  logic        trigger;
  logic        gb_clk;
  logic        gb_clk_rise;
  logic        halt;
  logic [31:0] cycle_count;

  logic        reset_h;
  logic        trigger_h;
  logic        gb_clk_h;
  logic        gb_clk_rise_h;
  logic        halt_h;
  logic [31:0] cycle_count_h;

  int tests_run;
  int tests_failed;

  // {gb_clk, gb_clk_rise, halt, cycle_count}
  logic [34:0] obs;
  logic [34:0] obs_h;
  logic [34:0] exp_v;

  assign obs   = {gb_clk, gb_clk_rise, halt, cycle_count};
  assign obs_h = {gb_clk_h, gb_clk_rise_h, halt_h, cycle_count_h};

  gb_clk_ctrl #(.HALF_PERIOD(4), .START_HALTED(1'b0)) dut (
    .clk         (clk),
    .reset       (reset),
    .trigger     (trigger),
    .gb_clk      (gb_clk),
    .gb_clk_rise (gb_clk_rise),
    .halt        (halt),
    .cycle_count (cycle_count)
  );

  gb_clk_ctrl #(.HALF_PERIOD(4), .START_HALTED(1'b1)) dut_h (
    .clk         (clk),
    .reset       (reset_h),
    .trigger     (trigger_h),
    .gb_clk      (gb_clk_h),
    .gb_clk_rise (gb_clk_rise_h),
    .halt        (halt_h),
    .cycle_count (cycle_count_h)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    reset_h   = 1'b1;
    trigger   = 1'b0;
    trigger_h = 1'b0;
    tick();
    tick();
    tests_run++;
    if (obs !== 35'h0) begin
      tests_failed++;
      $display("FAIL reset_state actual=%h required=%h", obs, 35'h0);
    end
    exp_v = {1'b0, 1'b0, 1'b1, 32'd0};
    tests_run++;
    if (obs_h !== exp_v) begin
      tests_failed++;
      $display("FAIL reset_state_halted actual=%h required=%h", obs_h, exp_v);
    end
    reset = 1'b0;
  endtask

  // Rises at 4, 12, 20 cycles after release.
  task automatic test_free_run();
    for (int t = 1; t <= 21; t++) begin
      tick();
      exp_v = {(t >= 4) && (((t - 4) % 8) < 4),
               (t >= 4) && (((t - 4) % 8) == 0),
               1'b0,
               (t < 4) ? 32'd0 : 32'((t - 4) / 8 + 1)};
      tests_run++;
      if (obs !== exp_v) begin
        tests_failed++;
        $display("FAIL free_run t=%0d actual=%h required=%h", t, obs, exp_v);
      end
    end
  endtask

  // Edge during the high phase: falls at 24, halts at 28 instead of rising.
  task automatic test_halt();
    trigger = 1'b1;
    for (int t = 22; t <= 28 + 50; t++) begin
      tick();
      trigger = 1'b0;
      if (t < 28) exp_v = {(t < 24), 1'b0, 1'b0, 32'd3};
      else        exp_v = {1'b0, 1'b0, 1'b1, 32'd3};
      tests_run++;
      if (obs !== exp_v) begin
        tests_failed++;
        $display("FAIL halt t=%0d actual=%h required=%h", t, obs, exp_v);
      end
    end
  endtask

  // Held trigger from HALTED: immediate rise, then keeps running.
  task automatic test_resume_held();
    trigger = 1'b1;
    for (int r = 0; r <= 16; r++) begin
      tick();
      if (r == 9) trigger = 1'b0;
      exp_v = {((r % 8) < 4), ((r % 8) == 0), 1'b0, 32'(4 + r / 8)};
      tests_run++;
      if (obs !== exp_v) begin
        tests_failed++;
        $display("FAIL resume_held r=%0d actual=%h required=%h", r, obs, exp_v);
      end
    end
  endtask

  task automatic test_single_step();
    // Halt first: edge right after the rise at r=16, halted at r=24.
    trigger = 1'b1;
    for (int r = 17; r <= 24; r++) begin
      tick();
      trigger = 1'b0;
    end
    exp_v = {1'b0, 1'b0, 1'b1, 32'd6};
    tests_run++;
    if (obs !== exp_v) begin
      tests_failed++;
      $display("FAIL step_prehalt actual=%h required=%h", obs, exp_v);
    end
    // Resume edge, then a second edge 2 cycles after the rise.
    trigger = 1'b1;
    for (int s = 0; s <= 12; s++) begin
      tick();
      trigger = (s == 2);
      exp_v = {(s < 4), (s == 0), (s >= 8), 32'd7};
      tests_run++;
      if (obs !== exp_v) begin
        tests_failed++;
        $display("FAIL single_step s=%0d actual=%h required=%h", s, obs, exp_v);
      end
    end
  endtask

  // Cancel edges: two edges 2 apart, then a cancel on the would-be rise.
  task automatic test_cancel();
    trigger = 1'b1;
    for (int u = 0; u <= 24; u++) begin
      tick();
      trigger = (u == 1) || (u == 3) || (u == 9) || (u == 15);
      exp_v = {((u % 8) < 4), ((u % 8) == 0), 1'b0, 32'(8 + u / 8)};
      tests_run++;
      if (obs !== exp_v) begin
        tests_failed++;
        $display("FAIL cancel u=%0d actual=%h required=%h", u, obs, exp_v);
      end
    end
    trigger = 1'b0;
  endtask

  task automatic test_async_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int t = 1; t <= 37; t++) tick();
    exp_v = {1'b1, 1'b0, 1'b0, 32'd5};
    tests_run++;
    if (obs !== exp_v) begin
      tests_failed++;
      $display("FAIL pre_reset_state actual=%h required=%h", obs, exp_v);
    end
    #2 reset = 1'b1;
    #1;
    tests_run++;
    if (obs !== 35'h0) begin
      tests_failed++;
      $display("FAIL async_reset actual=%h required=%h", obs, 35'h0);
    end
    tick();
    reset = 1'b0;

    // START_HALTED instance: stays halted until a trigger edge.
    reset_h = 1'b0;
    for (int t = 1; t <= 20; t++) begin
      tick();
      exp_v = {1'b0, 1'b0, 1'b1, 32'd0};
      tests_run++;
      if (obs_h !== exp_v) begin
        tests_failed++;
        $display("FAIL start_halted t=%0d actual=%h required=%h", t, obs_h, exp_v);
      end
    end
    trigger_h = 1'b1;
    for (int r = 0; r <= 3; r++) begin
      tick();
      trigger_h = 1'b0;
      exp_v = {1'b1, (r == 0), 1'b0, 32'd1};
      tests_run++;
      if (obs_h !== exp_v) begin
        tests_failed++;
        $display("FAIL start_halted_resume r=%0d actual=%h required=%h", r, obs_h, exp_v);
      end
    end
    #2 reset_h = 1'b1;
    #1;
    exp_v = {1'b0, 1'b0, 1'b1, 32'd0};
    tests_run++;
    if (obs_h !== exp_v) begin
      tests_failed++;
      $display("FAIL async_reset_halted actual=%h required=%h", obs_h, exp_v);
    end
    // Trigger already high at release acts as an edge in the first cycle.
    trigger_h = 1'b1;
    tick();
    reset_h = 1'b0;
    tick();
    exp_v = {1'b1, 1'b1, 1'b0, 32'd1};
    tests_run++;
    if (obs_h !== exp_v) begin
      tests_failed++;
      $display("FAIL trigger_at_release actual=%h required=%h", obs_h, exp_v);
    end
    trigger_h = 1'b0;
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    test_reset();
    test_free_run();
    test_halt();
    test_resume_held();
    test_single_step();
    test_cancel();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
